// File: rtl/adc_responder.sv
// adc_responder
//   SPI-slave model of the 12-bit serial ADC that the ADC controller talks to.
//   A rising edge on adc_convst latches sample_in, holds busy for CONV_CYCLES
//   clk cycles, then returns the sample LSB first on adc_sdo, advancing one bit
//   per adc_sck rising edge. During the same frame the first six adc_sck falling
//   edges capture a 6-bit configuration word from adc_sdi (MSB first).
//   All inputs come from registers on clk, so edges are detected against
//   one-cycle-delayed copies and no synchronizers are used.
//
// Optional feature: define ADC_RESP_ERR_EN to build the sticky protocol-error
//   flag. Without it, err is tied to 0.
//
// Ports
//   clk         system clock (also the clock that generates adc_sck/adc_convst)
//   reset       asynchronous, active-low reset
//   adc_convst  conversion trigger, rising edge starts a frame
//   adc_sck     serial clock from the controller
//   adc_sdi     configuration bit stream, MSB first
//   adc_sdo     conversion data, LSB first
//   sample_in   value to "convert", latched at conversion start
//   conf_out    last complete configuration word
//   conf_valid  one-cycle pulse when conf_out updates
//   busy        high while converting
//   err         sticky protocol-error flag
//   state_dbg   current FSM state (0 IDLE, 1 CONVERT, 2 SHIFT, 3 DONE)
module adc_responder #(
  parameter int CONV_CYCLES = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_convst,
  input  logic        adc_sck,
  input  logic        adc_sdi,
  output logic        adc_sdo,
  input  logic [11:0] sample_in,
  output logic [5:0]  conf_out,
  output logic        conf_valid,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        sck_q, cst_q;
  logic [11:0] data_sr;
  logic [3:0]  rx_cnt;     // 0..12
  logic [2:0]  cf_cnt;     // 0..6
  logic [4:0]  cfg_sr;     // first five config bits; the sixth goes straight to conf_out
  logic [3:0]  conv_cnt;

  logic sck_rise, sck_fall, cst_rise;
  logic shift_rise, shift_fall;

  assign sck_rise = adc_sck & ~sck_q;
  assign sck_fall = ~adc_sck & sck_q;
  assign cst_rise = adc_convst & ~cst_q;

  // A convst rise takes priority: any sck edge on the same clk is dropped.
  assign shift_rise = (state == S_SHIFT) && sck_rise && !cst_rise && (rx_cnt < 4'd12);
  assign shift_fall = (state == S_SHIFT) && sck_fall && !cst_rise && (cf_cnt < 3'd6);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (cst_rise) begin
      state_nx = S_CONVERT;
    end else begin
      case (state)
        S_CONVERT: if (conv_cnt <= 4'd1) state_nx = S_SHIFT;
        S_SHIFT:   if (shift_rise && rx_cnt == 4'd11) state_nx = S_DONE;
        default:   state_nx = state;
      endcase
    end
  end

  // Outputs decoded from state and registers. data_sr is zero-filled as it
  // shifts, so after the twelfth shift (and after reset) adc_sdo reads 0.
  always_comb begin
    busy      = (state == S_CONVERT);
    adc_sdo   = data_sr[0];
    state_dbg = state;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q      <= 1'b0;
      cst_q      <= 1'b0;
      data_sr    <= '0;
      rx_cnt     <= '0;
      cf_cnt     <= '0;
      cfg_sr     <= '0;
      conv_cnt   <= '0;
      conf_out   <= '0;
      conf_valid <= 1'b0;
    end else begin
      sck_q      <= adc_sck;
      cst_q      <= adc_convst;
      conf_valid <= 1'b0;
      if (cst_rise) begin
        data_sr  <= sample_in;
        rx_cnt   <= '0;
        cf_cnt   <= '0;
        conv_cnt <= 4'(CONV_CYCLES);
      end else begin
        if (state == S_CONVERT && conv_cnt != 4'd0)
          conv_cnt <= conv_cnt - 4'd1;
        if (shift_rise) begin
          data_sr <= {1'b0, data_sr[11:1]};
          rx_cnt  <= rx_cnt + 4'd1;
        end
        if (shift_fall) begin
          cfg_sr <= {cfg_sr[3:0], adc_sdi};
          cf_cnt <= cf_cnt + 3'd1;
          if (cf_cnt == 3'd5) begin
            conf_out   <= {cfg_sr, adc_sdi};
            conf_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef ADC_RESP_ERR_EN
  // Protocol errors: sck rise while converting or after the frame is done,
  // or a new conversion before all twelve bits were read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if ((sck_rise && !cst_rise && (state == S_CONVERT || state == S_DONE)) ||
                 (cst_rise && state == S_SHIFT && rx_cnt < 4'd12)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_responder.sv
module tb_adc_responder;

  localparam int CONV = 4;
`ifdef ADC_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic [11:0] sample_in;
  logic [5:0]  conf_out;
  logic        conf_valid;
  logic        busy;
  logic        err;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int cv_cnt   = 0;

  logic [11:0] exp_q[$];

  adc_responder #(.CONV_CYCLES(CONV)) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo),
    .sample_in  (sample_in),
    .conf_out   (conf_out),
    .conf_valid (conf_valid),
    .busy       (busy),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // One clk edge; inputs set before the call are sampled at that edge and
  // outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_cnt++;
    if (conf_valid === 1'b1) cv_cnt++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc_convst = 1'($urandom_range(0, 1));
      adc_sck    = 1'($urandom_range(0, 1));
      adc_sdi    = 1'($urandom_range(0, 1));
      sample_in  = 12'($urandom);
      tick();
    end
    check("rst_sdo", 32'(adc_sdo), 32'd0);
    check("rst_conf_out", 32'(conf_out), 32'd0);
    check("rst_conf_valid", 32'(conf_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    adc_convst = 1'b0;
    adc_sck    = 1'b0;
    adc_sdi    = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Convst pulse, then wait until the first sck rise may legally be sent.
  task automatic start_frame(input logic [11:0] s, input int extra);
    sample_in  = s;
    adc_convst = 1'b1;
    busy_cnt   = 0;
    cv_cnt     = 0;
    tick();
    adc_convst = 1'b0;
    repeat (CONV + extra) tick();
  endtask

  // Clock nbits sck periods; capture adc_sdo as the controller would, i.e.
  // the value present when sck goes high. sdi carries w MSB first, then 0.
  task automatic clock_out(input logic [5:0] w, input int half, input int nbits,
                           output logic [11:0] bits);
    logic [5:0] sh;
    sh   = w;
    bits = '0;
    for (int i = 0; i < nbits; i++) begin
      adc_sdi = sh[5];
      sh      = sh << 1;
      if (i < 12) bits[i] = adc_sdo;
      adc_sck = 1'b1;
      repeat (half) tick();
      adc_sck = 1'b0;
      repeat (half) tick();
    end
  endtask

  task automatic run_frame(input logic [11:0] s, input logic [5:0] w, input int extra,
                           input int half, output logic [11:0] bits, output logic [11:0] tail);
    start_frame(s, extra);
    clock_out(w, half, 12, bits);
    clock_out(6'h00, half, 2, tail);  // surplus sck edges after the frame
    repeat (2) tick();
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    logic [11:0] sample;
    logic [5:0]  word;
    int          half;
    logic [11:0] exp_bits;   // bit n = adc_sdo seen at sck rise n+1
    logic [5:0]  exp_conf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [11:0] bits, tail, eb;
    logic [11:0] rs;
    logic [5:0]  rw;

    // Full frame A5C: 0,0,1,1,1,0,1,0,0,1,0,1 LSB first; config 101101.
    vecs[0] = '{12'hA5C, 6'b101101, 1, 12'b1010_0101_1100, 6'h2D};
    vecs[1] = '{12'h0FF, 6'b111111, 1, 12'b0000_1111_1111, 6'h3F};
    vecs[2] = '{12'hF00, 6'b000000, 2, 12'b1111_0000_0000, 6'h00};
    vecs[3] = '{12'h001, 6'b010101, 1, 12'b0000_0000_0001, 6'h15};
    vecs[4] = '{12'hFFF, 6'b101010, 3, 12'b1111_1111_1111, 6'h2A};

    reset = 1'b0; adc_convst = 1'b0; adc_sck = 1'b0; adc_sdi = 1'b0; sample_in = '0;
    do_reset();

    // Idle after reset: sck toggles without convst leave sdo and busy at 0.
    busy_cnt = 0;
    clock_out(6'h3F, 1, 4, bits);
    check("idle_sdo", 32'(bits), 32'd0);
    check("idle_busy", 32'(busy_cnt), 32'd0);

    // Early sck: rise one clk after the convst rise is detected is ignored.
    do_reset();
    sample_in  = 12'h5A3;
    adc_convst = 1'b1;
    busy_cnt   = 0;
    tick();
    check("early_first_bit", 32'(adc_sdo), 32'd1);
    adc_convst = 1'b0;
    adc_sck    = 1'b1;
    tick();
    check("early_sdo_held", 32'(adc_sdo), 32'd1);
    check("early_err", 32'(err), 32'(ERR_EN));
    adc_sck = 1'b0;
    repeat (CONV - 1) tick();
    check("early_busy_len", 32'(busy_cnt), 32'(CONV));
    clock_out(6'h00, 1, 12, bits);
    check("early_bits", 32'(bits), 32'h5A3);

    // Abort: restart after five sck rises with a new sample.
    do_reset();
    start_frame(12'hA5C, 0);
    clock_out(6'h3F, 1, 5, bits);
    check("abort_partial", 32'(bits[4:0]), 32'(5'b11100));
    run_frame(12'h001, 6'h15, 0, 1, bits, tail);
    check("abort_bits", 32'(bits), 32'h001);
    check("abort_conf", 32'(conf_out), 32'h15);
    check("abort_cv_pulses", 32'(cv_cnt), 32'd1);
    check("abort_err", 32'(err), 32'(ERR_EN));

    // Table: consecutive frames, no reset in between.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].sample, vecs[v].word, v % 2, vecs[v].half, bits, tail);
      check($sformatf("vec%0d_bits", v), 32'(bits), 32'(vecs[v].exp_bits));
      check($sformatf("vec%0d_tail", v), 32'(tail), 32'd0);
      check($sformatf("vec%0d_sdo_after", v), 32'(adc_sdo), 32'd0);
      check($sformatf("vec%0d_conf", v), 32'(conf_out), 32'(vecs[v].exp_conf));
      check($sformatf("vec%0d_cv_pulses", v), 32'(cv_cnt), 32'd1);
      check($sformatf("vec%0d_busy_len", v), 32'(busy_cnt), 32'(CONV));
    end

    // Random frames against the reference: sdo delivers the latched sample
    // LSB first, twelve bits, then zeros; conf_out is the sdi word.
    for (int f = 0; f < 20; f++) begin
      rs = 12'($urandom);
      rw = 6'($urandom);
      exp_q.delete();
      for (int i = 0; i < 12; i++) exp_q.push_back(12'((rs >> i) & 12'd1));
      run_frame(rs, rw, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), bits, tail);
      for (int i = 0; i < 12; i++) begin
        eb = exp_q.pop_front();
        check($sformatf("rnd%0d_bit%0d", f, i), 32'(bits[i]), 32'(eb[0]));
      end
      check($sformatf("rnd%0d_tail", f), 32'(tail), 32'd0);
      check($sformatf("rnd%0d_conf", f), 32'(conf_out), 32'(rw));
      check($sformatf("rnd%0d_cv", f), 32'(cv_cnt), 32'd1);
      check($sformatf("rnd%0d_busy", f), 32'(busy_cnt), 32'(CONV));
    end

    // Reset mid-frame, then sck with no convst must not produce data.
    start_frame(12'hFFF, 0);
    clock_out(6'h00, 1, 3, bits);
    do_reset();
    busy_cnt = 0;
    cv_cnt   = 0;
    clock_out(6'h3F, 1, 8, bits);
    check("midrst_sdo", 32'(bits), 32'd0);
    check("midrst_busy", 32'(busy_cnt), 32'd0);
    check("midrst_cv", 32'(cv_cnt), 32'd0);
    check("midrst_conf", 32'(conf_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
# adc_responder

Synchronous SPI-slave model of the 12-bit serial ADC driven by the team's ADC controller. It accepts the controller's `adc_convst`, `adc_sck` and `adc_sdi` and returns conversion data on `adc_sdo`. It is used as the bench-side and FPGA-loopback counterpart of the controller. All inputs are sampled on `clk`, the same clock that generates `adc_sck`, so the block has no synchronizers and no second clock domain.

## Interface
- `CONV_CYCLES`, 1: number of `clk` cycles `busy` stays high after a detected conversion start; legal range 1..15.
- `clk`  in  1  system clock; the controller's `adc_sck`/`adc_convst` are registers on this clock.
- `reset`  in  1  asynchronous, active-low reset.
- `adc_convst`  in  1  conversion trigger; the rising edge starts a conversion.
- `adc_sck`  in  1  serial clock from the controller.
- `adc_sdi`  in  1  configuration bit stream, MSB first.
- `adc_sdo`  out  1  conversion data, LSB first.
- `sample_in`  in  12  analog value to be "converted"; latched at conversion start.
- `conf_out`  out  6  last complete configuration word received.
- `conf_valid`  out  1  one-cycle pulse when `conf_out` updates.
- `busy`  out  1  high during CONVERT.
- `err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Edge detection: registered copies `sck_q` and `cst_q`.
  - sck rise = `adc_sck & ~sck_q`; sck fall = `~adc_sck & sck_q`; convst rise defined the same way.
  - All actions take place on the `clk` edge at which the detection is true.
- State machine: IDLE, CONVERT, SHIFT, DONE.
  - IDLE: wait for convst rise.
  - Any state, convst rise: load `sample_in` into the 12-bit shift register, drive `adc_sdo = sample_in[0]`, clear the bit counter `rx_cnt` (0..12) and the config counter `cf_cnt` (0..6), load the conversion counter with `CONV_CYCLES`, and go to CONVERT. A convst rise during SHIFT or DONE aborts the frame and restarts it.
  - CONVERT: `busy = 1`; decrement the counter each cycle and go to SHIFT when it reaches 0. sck edges in this state are ignored.
  - SHIFT, sck rise: shift the register right with zero fill, so `adc_sdo` presents the next bit; increment `rx_cnt`. At `rx_cnt == 12`, go to DONE with `adc_sdo = 0`.
  - SHIFT, sck fall with `cf_cnt < 6`: shift `adc_sdi` into the config shift register MSB first; increment `cf_cnt`. When `cf_cnt` reaches 6, update `conf_out` and pulse `conf_valid`.
  - DONE: `adc_sdo` held at 0. sck edges ignored. Wait for convst rise.
- The controller samples `adc_sdo` on the sck rising edge. Bit n therefore stays stable from the preceding shift until the clk edge that detects the nth rising edge.
- Simultaneous convst rise and sck edge: convst wins and the sck edge is discarded.
- Width rules: `rx_cnt` saturates at 12 and `cf_cnt` at 6. Extra sck edges never wrap either counter.

## Timing
- Reset values: `adc_sdo = 0`, `conf_out = 0`, `conf_valid = 0`, `busy = 0`, `err = 0`, state IDLE, all counters 0.
- Reset asserted mid-frame returns everything to the reset values immediately; the next frame needs a new convst rise.
- convst rise occurs at clk edge k and is detected at edge k+1. At k+1, `adc_sdo = sample_in[0]` and `busy = 1`. `busy` falls at edge k+1+`CONV_CYCLES`.
- With the default `CONV_CYCLES = 1`, the first sck rise may come 2 edges after convst rise. The controller's gap is 3 edges, so it is met.
- `adc_sdo` changes exactly one clk after each sck rise. With sck toggling every clk, that change falls in the sck low phase.
- `conf_valid` asserts one clk after the 6th sck fall is detected and lasts one cycle.

## Configuration
- `ADC_RESP_ERR_EN` defined: `err` is set (sticky until reset) on any of:
  - an sck rise in CONVERT;
  - an sck rise in DONE;
  - a convst rise in SHIFT with `rx_cnt < 12`.
- Not defined: `err` is tied to 0 and no error logic is generated. All other behaviour is identical.

## Test plan
- Reset: hold `reset = 0` with random inputs, then release -> all outputs 0, `adc_sdo` stays 0 with no convst.
- Full frame: `sample_in = 12'hA5C`, convst pulse, then 12 sck periods at clk/2 -> `adc_sdo` sampled at sck rises = 0,0,1,1,1,0,1,0,0,1,0,1; `adc_sdo = 0` afterwards.
- Config: `adc_sdi` presents 6'b101101 on sck rises 1..6 -> `conf_out = 6'h2D`, one `conf_valid` pulse after the 6th fall, no further pulses in the frame.
- Abort: convst rise after 5 sck rises with new `sample_in = 12'h001` -> restart; the next 12 bits return 1 followed by eleven 0s. With `ADC_RESP_ERR_EN`, `err = 1`.
- Early sck: `CONV_CYCLES = 4`, sck rise 1 clk after convst is detected -> edge ignored, `adc_sdo` still holds bit 0. `err = 1` only with the macro defined.
- Back-to-back: two frames with 12'h0FF then 12'hF00 -> each frame returns its own value, and `busy` pulses for `CONV_CYCLES` in each frame.
